// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit block: widths, default FIFO depth, entry record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

   localparam int WB_XLEN  = 32;
   localparam int WB_AW    = 5;
   localparam int WB_DEPTH = 4;

   // One buffered result. rd sits in the upper bits so a scan of the upper
   // field of a packed entry yields the destination index.
   typedef struct packed {
      logic [WB_AW-1:0]   rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with an age-ordered view of its occupied entries.
// Latency: push visible at head one edge after the write; pop takes effect on the edge.
// Backpressure: push ignored while full, pop ignored while empty; caller gates with full/count.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset (pointers/count only)
//   push, push_data       write push_data at the tail
//   pop                   retire the head entry
//   head_data             oldest entry
//   full, empty, count    occupancy
//   entry_valid[k]        age slot k (0 = head) holds a live entry
//   scan[k]               upper SCAN_W bits of the entry in age slot k
module wb_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int SCAN_W = WIDTH
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DEPTH-1:0]         entry_valid,
   output logic [DEPTH*SCAN_W-1:0]  scan
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];

   // Rotate the ring so slot 0 is the head; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      entry_valid = '0;
      scan        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         entry_valid[k]               = (CW'(k) < cnt);
         scan[k*SCAN_W +: SCAN_W]     = mem[rd_ptr + PW'(k)][WIDTH-1 -: SCAN_W];
      end
   end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit: arbitrates ALU/load results into an in-order FIFO and drives one register-file write per cycle.
// Latency: result accepted at edge N commits at edge N+1 at the earliest (regwrite high after N+1).
// Backpressure: mem_ready = !full, alu_ready = !full && !mem_valid; no path from wb_hold to ready.
//
// Ports:
//   clock, reset                         rising-edge clock, async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result channel
//   mem_valid/mem_ready/mem_rd/mem_data  load result channel (priority over ALU)
//   wb_hold                              suppress this cycle's commit
//   regwrite/write_reg/write_data        registered register-file write port
//   pending_mask                         bit r set while an uncommitted result targets xr
//   full, empty                          FIFO occupancy
// Optional (WB_BYPASS_EN defined): byp_rs1/byp_rs2 lookups returning byp_hit1/2 and byp_data1/2
// from the youngest buffered entry with a matching destination.
module wb_commit_unit
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int XLEN  = WB_XLEN,
   parameter int AW    = WB_AW
)(
   input  logic            clock,
   input  logic            reset,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            wb_hold,
   output logic            regwrite,
   output logic [AW-1:0]   write_reg,
   output logic [XLEN-1:0] write_data,
   output logic [31:0]     pending_mask,
`ifdef WB_BYPASS_EN
   input  logic [AW-1:0]   byp_rs1,
   input  logic [AW-1:0]   byp_rs2,
   output logic            byp_hit1,
   output logic            byp_hit2,
   output logic [XLEN-1:0] byp_data1,
   output logic [XLEN-1:0] byp_data2,
`endif
   output logic            full,
   output logic            empty
);

   localparam int EW = AW + XLEN;
   localparam int CW = $clog2(DEPTH) + 1;
   // The scan exposes only rd for the mask, or the whole entry when bypass needs data.
`ifdef WB_BYPASS_EN
   localparam int SW = EW;
`else
   localparam int SW = AW;
`endif

   logic            mem_fire;
   logic            alu_fire;
   logic            push;
   logic            pop;
   logic [AW-1:0]   acc_rd;
   logic [XLEN-1:0] acc_data;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [DEPTH-1:0]    entry_valid;
   logic [DEPTH*SW-1:0] scan;
   logic [EW-1:0]   head;
   logic [AW-1:0]   scan_rd [DEPTH];

   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
   assign mem_ready = !fifo_full;
   assign alu_ready = !fifo_full && !mem_valid;
   assign mem_fire  = mem_valid && mem_ready;
   assign alu_fire  = alu_valid && alu_ready;

   assign acc_rd   = mem_fire ? mem_rd   : alu_rd;
   assign acc_data = mem_fire ? mem_data : alu_data;

   // x0 results complete their handshake but are dropped here.
   assign push = (mem_fire || alu_fire) && (acc_rd != '0);
   assign pop  = (fifo_count != '0) && !wb_hold;

   assign full  = fifo_full;
   assign empty = fifo_empty;

   wb_fifo #(
      .WIDTH  (EW),
      .DEPTH  (DEPTH),
      .SCAN_W (SW)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .push_data   ({acc_rd, acc_data}),
      .pop         (pop),
      .head_data   (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .entry_valid (entry_valid),
      .scan        (scan)
   );

   // write_reg/write_data keep their last committed values on idle cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
         regwrite <= pop;
         if (pop) begin
            write_reg  <= head[EW-1 -: AW];
            write_data <= head[XLEN-1:0];
         end
      end
   end

   // The head stays in the mask until the edge that pops it.
   always_comb begin
      pending_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_rd[k] = scan[k*SW + SW - AW +: AW];
         if (entry_valid[k]) pending_mask[scan_rd[k]] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Walk head to tail so the youngest match overwrites older ones.
   always_comb begin
      byp_hit1  = 1'b0;
      byp_hit2  = 1'b0;
      byp_data1 = '0;
      byp_data2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (entry_valid[k] && (byp_rs1 != '0) && (scan_rd[k] == byp_rs1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = scan[k*SW +: XLEN];
         end
         if (entry_valid[k] && (byp_rs2 != '0) && (scan_rd[k] == byp_rs2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = scan[k*SW +: XLEN];
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_commit_unit;
   import wb_pkg::*;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_rd = '0;
   logic [31:0] mem_data = '0;
   logic        wb_hold = 1'b0;
   logic        regwrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] pending_mask;
   logic        full;
   logic        empty;
`ifdef WB_BYPASS_EN
   logic [4:0]  byp_rs1 = '0;
   logic [4:0]  byp_rs2 = '0;
   logic        byp_hit1, byp_hit2;
   logic [31:0] byp_data1, byp_data2;
`endif

   always #5 clock = ~clock;

   wb_commit_unit #(.DEPTH(D), .XLEN(32), .AW(5)) dut (
      .clock        (clock),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .wb_hold      (wb_hold),
      .regwrite     (regwrite),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .pending_mask (pending_mask),
`ifdef WB_BYPASS_EN
      .byp_rs1      (byp_rs1),
      .byp_rs2      (byp_rs2),
      .byp_hit1     (byp_hit1),
      .byp_hit2     (byp_hit2),
      .byp_data1    (byp_data1),
      .byp_data2    (byp_data2),
`endif
      .full         (full),
      .empty        (empty)
   );

   int errors = 0;
   int checks = 0;

   // Model: buffered results in acceptance order plus the expected write port.
   wb_entry_t   q[$];
   logic        m_rw = 1'b0;
   logic [4:0]  m_wr = '0;
   logic [31:0] m_wd = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      logic [31:0] m;
      logic        f;
      m = '0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      m[0] = 1'b0;
      f = (q.size() == D);
      chk("alu_ready", alu_ready, !f && !mem_valid);
      chk("mem_ready", mem_ready, !f);
      chk("full", full, f);
      chk("empty", empty, q.size() == 0);
      chk("pending_mask", pending_mask, m);
      chk("regwrite", regwrite, m_rw);
      chk("write_reg", write_reg, m_wr);
      chk("write_data", write_data, m_wd);
`ifdef WB_BYPASS_EN
      begin
         logic h1, h2;
         logic [31:0] d1, d2;
         h1 = 0; h2 = 0; d1 = 0; d2 = 0;
         foreach (q[i]) begin
            if (byp_rs1 != 0 && q[i].rd == byp_rs1) begin h1 = 1; d1 = q[i].data; end
            if (byp_rs2 != 0 && q[i].rd == byp_rs2) begin h2 = 1; d2 = q[i].data; end
         end
         chk("byp_hit1", byp_hit1, h1);
         chk("byp_data1", byp_data1, d1);
         chk("byp_hit2", byp_hit2, h2);
         chk("byp_data2", byp_data2, d2);
      end
`endif
   endtask

   // One clock cycle: drive at the falling edge, check, advance the model, return just after the rising edge.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic hold);
      logic      acc;
      wb_entry_t e;
      @(negedge clock);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      wb_hold = hold;
`ifdef WB_BYPASS_EN
      byp_rs1 = 5'($urandom_range(0, 7));
      byp_rs2 = 5'($urandom_range(0, 7));
`endif
      #1;
      compare();
      acc = 1'b0;
      e = '0;
      if (q.size() < D) begin
         if (mv) begin acc = 1'b1; e.rd = mrd; e.data = md; end
         else if (av) begin acc = 1'b1; e.rd = ard; e.data = ad; end
      end
      if (q.size() > 0 && !hold) begin
         m_rw = 1'b1; m_wr = q[0].rd; m_wd = q[0].data;
         void'(q.pop_front());
      end else begin
         m_rw = 1'b0;
      end
      if (acc && e.rd != 0) q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic hold);
      step(0, 0, 0, 0, 0, 0, hold);
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_regwrite", regwrite, 0);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_mask", pending_mask, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Single ALU write to x5
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      chk("t1_mask", pending_mask, 32'h0000_0020);
      chk("t1_no_write_yet", regwrite, 0);
      idle(0);
      chk("t1_regwrite", regwrite, 1);
      chk("t1_write_reg", write_reg, 5);
      chk("t1_write_data", write_data, 32'hDEADBEEF);
      chk("t1_empty", empty, 1);
      chk("t1_mask_clear", pending_mask, 0);

      // Both channels valid: load wins, ALU follows
      step(1, 4, 32'h22, 1, 3, 32'h11, 0);
      chk("t2_mask_x3", pending_mask, 32'h0000_0008);
      step(1, 4, 32'h22, 0, 0, 0, 0);
      chk("t2_first_reg", write_reg, 3);
      chk("t2_first_data", write_data, 32'h11);
      chk("t2_mask_x4", pending_mask, 32'h0000_0010);
      idle(0);
      chk("t2_second_reg", write_reg, 4);
      chk("t2_second_data", write_data, 32'h22);

      // Fill under hold, then drain in order
      for (int i = 1; i <= 5; i++) step(1, 5'(i), 32'h100 + i, 0, 0, 0, 1);
      chk("t3_full", full, 1);
      chk("t3_mask", pending_mask, 32'h0000_001E);
      chk("t3_alu_ready", alu_ready, 0);
      for (int k = 1; k <= 4; k++) begin
         idle(0);
         chk("t3_drain_rw", regwrite, 1);
         chk("t3_drain_reg", write_reg, 5'(k));
         chk("t3_drain_data", write_data, 32'h100 + k);
      end
      step(1, 5, 32'h105, 0, 0, 0, 0);
      idle(0);
      chk("t3_x5_reg", write_reg, 5);
      chk("t3_x5_data", write_data, 32'h105);

      // x0 is dropped
      step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
      chk("t4_mask", pending_mask, 0);
      chk("t4_empty", empty, 1);
      idle(0);
      chk("t4_no_write", regwrite, 0);

      // Same destination twice: last one wins
      step(1, 7, 32'h1, 0, 0, 0, 0);
      step(1, 7, 32'h2, 0, 0, 0, 0);
      idle(0);
      chk("t5_reg", write_reg, 7);
      chk("t5_data", write_data, 32'h2);

      // Reset with three entries buffered
      for (int i = 0; i < 3; i++) step(1, 5'(9 + i), 32'hA0 + i, 0, 0, 0, 1);
      chk("t6_mask_before", pending_mask, 32'h0000_0E00);
      @(negedge clock);
      alu_valid = 0; mem_valid = 0; wb_hold = 0;
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_regwrite", regwrite, 0);
      chk("t6_rst_write_reg", write_reg, 0);
      chk("t6_rst_write_data", write_data, 0);
      chk("t6_rst_mask", pending_mask, 0);
      chk("t6_rst_empty", empty, 1);
      q.delete();
      m_rw = 0; m_wr = 0; m_wd = 0;
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         idle(0);
         chk("t6_no_write", regwrite, 0);
      end

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) == 0);
      end
      for (int n = 0; n < 8; n++) idle(0);
      chk("final_empty", empty, 1);
      chk("final_mask", pending_mask, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
